fetch_prefetch_queue: RTL

//  Instruction-fetch front end for the pipelined RISC-V core. It replaces the fixed
//  PCF->imem->InstrD path with a parametrised prefetch queue. Features:
//  - request/response handshake to a variable-latency instruction memory;
//  - up to MAX_OUT fetches in flight;
//  - DEPTH-entry in-order buffer feeding the F/D pipeline register;
//  - redirect on taken branch/jump (PCSrcE), which squashes queued and in-flight fetches.
//  It sits between imem and decode; stallD/FlushD come from HazardUnit.

---
 rtl/fetch_prefetch_queue.sv | 132 +++++++++++++
 1 files changed

// File: rtl/fetch_prefetch_queue.sv
// Instruction-fetch front end: issues imem requests ahead of decode, buffers returned
// words in order and feeds the F/D register; a redirect squashes queued and in-flight work.
module fetch_prefetch_queue #(
  parameter int XLEN = 32,
  parameter int DEPTH = 4,
  parameter int MAX_OUT = 2,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            reset,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_resp_valid,
  input  logic [31:0]     imem_resp_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic            stallD,
  input  logic            FlushD,
  output logic [31:0]     InstrD,
  output logic [XLEN-1:0] PCD,
  output logic [XLEN-1:0] PCPlus4D,
  output logic            validD
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);

  logic [31:0]     r_qData [DEPTH];
  logic [XLEN-1:0] r_qPc   [DEPTH];
  logic [AW-1:0]   r_head;
  logic [AW-1:0]   r_tail;
  logic [CW-1:0]   r_count;
  logic [CW-1:0]   r_outstanding;
  logic [CW-1:0]   r_drop;
  logic [XLEN-1:0] r_fetchPc;
  logic [XLEN-1:0] r_respPc;

  logic [31:0]     r_instrD;
  logic [XLEN-1:0] r_pcD;
  logic [XLEN-1:0] r_pcPlus4D;
  logic            r_validD;

  logic w_respLive;
  logic w_push;
  logic w_dropResp;
  logic w_pop;
  logic w_budget;
  logic w_accept;

  // Queued entries plus in-flight fetches may never exceed the queue size, so a push always has room.
  assign w_budget   = ({1'b0, r_count} + {1'b0, r_outstanding}) < (CW+1)'(DEPTH);
  assign imem_req_valid = !reset && !redirect_valid && w_budget &&
                          (r_outstanding < CW'(MAX_OUT));
  assign imem_req_addr  = r_fetchPc;
  assign w_accept   = imem_req_valid && imem_req_ready;

  assign w_respLive = imem_resp_valid && (r_outstanding != '0);
  assign w_dropResp = w_respLive && (r_drop != '0);
  assign w_push     = w_respLive && (r_drop == '0) && !redirect_valid;
  assign w_pop      = !redirect_valid && !FlushD && !stallD && (r_count != '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_fetchPc     <= RESET_PC;
      r_respPc      <= RESET_PC;
      r_head        <= '0;
      r_tail        <= '0;
      r_count       <= '0;
      r_outstanding <= '0;
      r_drop        <= '0;
    end else begin
      r_outstanding <= r_outstanding + CW'(w_accept) - CW'(w_respLive);
      if (redirect_valid) begin
        // Everything still in flight after this edge belongs to the squashed path.
        r_drop    <= r_outstanding - CW'(w_respLive);
        r_fetchPc <= redirect_pc;
        r_respPc  <= redirect_pc;
        r_head    <= '0;
        r_tail    <= '0;
        r_count   <= '0;
      end else begin
        if (w_accept) r_fetchPc <= r_fetchPc + PC_STEP;
        if (w_dropResp) r_drop <= r_drop - CW'(1);
        if (w_push) begin
          r_tail   <= r_tail + AW'(1);
          r_respPc <= r_respPc + PC_STEP;
        end
        if (w_pop) r_head <= r_head + AW'(1);
        r_count <= r_count + CW'(w_push) - CW'(w_pop);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_qData[r_tail] <= imem_resp_data;
      r_qPc[r_tail]   <= r_respPc;
    end
  end

  // F/D register: redirect beats flush beats stall; no bypass from response to decode.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_instrD   <= NOP;
      r_pcD      <= '0;
      r_pcPlus4D <= '0;
      r_validD   <= 1'b0;
    end else if (redirect_valid || FlushD) begin
      r_instrD <= NOP;
      r_validD <= 1'b0;
    end else if (!stallD) begin
      if (r_count != '0) begin
        r_instrD   <= r_qData[r_head];
        r_pcD      <= r_qPc[r_head];
        r_pcPlus4D <= r_qPc[r_head] + PC_STEP;
        r_validD   <= 1'b1;
      end else begin
        r_instrD <= NOP;
        r_validD <= 1'b0;
      end
    end
  end

  assign InstrD   = r_instrD;
  assign PCD      = r_pcD;
  assign PCPlus4D = r_pcPlus4D;
  assign validD   = r_validD;

endmodule
